// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter
module bin2bcd_seq #(
    parameter int N      = 32,
    parameter int SIGNED = 0,
    parameter int STEPS  = 1,
    localparam int DIGITS = ((N * 1233) >> 12) + 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [N-1:0]          V,
    output logic                  Ready,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  Sign
);

    localparam int K  = N / STEPS;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    if ((N % STEPS) != 0) begin : g_bad_steps
        $error("bin2bcd_seq: N must be a multiple of STEPS");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                state_q;
    logic                  ready_q;
    logic                  done_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  sign_q;
    logic [4*DIGITS-1:0]   dig_q;
    logic [N-1:0]          bin_q;
    logic                  neg_q;
    logic [CW-1:0]         cnt_q;

    logic [4*DIGITS-1:0]   dig_d;
    logic [N-1:0]          bin_d;
    logic                  neg_in;
    logic [N-1:0]          mag_in;

    // Magnitude of the incoming value; the most negative value wraps to 2^(N-1) unsigned.
    always_comb begin
        neg_in = (SIGNED != 0) && V[N-1];
        mag_in = neg_in ? ((~V) + N'(1)) : V;
    end

    // STEPS rounds of add-3 correction followed by a one-bit shift of {digits, bin}.
    always_comb begin
        dig_d = dig_q;
        bin_d = bin_q;
        for (int s = 0; s < STEPS; s++) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (dig_d[4*j +: 4] >= 4'd5) begin
                    dig_d[4*j +: 4] = dig_d[4*j +: 4] + 4'd3;
                end
            end
            dig_d = {dig_d[4*DIGITS-2:0], bin_d[N-1]};
            bin_d = bin_d << 1;
        end
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            dig_q   <= '0;
            bin_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        bin_q   <= mag_in;
                        neg_q   <= neg_in;
                        dig_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CONVERT;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_CONVERT: begin
                    dig_q <= dig_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        bcd_q   <= dig_d;
                        // A negative input always has a nonzero magnitude.
                        sign_q  <= neg_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Ready = ready_q;
    assign Done  = done_q;
    assign BCD   = bcd_q;
    assign Sign  = sign_q;

endmodule
